regfile_write_arbiter: RTL and testbench

Shares the single write port of the 16x16 register_file (clk, rst, reg_write_en, reg_write_dest, reg_write_data) between NUM_REQ writeback requesters using round-robin arbitration with a valid/ready handshake.
Also contains a clear sequencer that writes zero to every register, one per cycle, on request.
Sits between the writeback sources (ALU, load unit, debug) and the register_file write port.
Read ports are not touched.

---
 rtl/regfile_write_arbiter_pkg.sv | 14 +
 rtl/regfile_write_arbiter_if.sv | 29 ++
 rtl/regfile_write_arbiter_rr_arbiter.sv | 50 +++++
 rtl/regfile_write_arbiter.sv | 118 +++++++++++
 tb/tb_regfile_write_arbiter.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants and FSM state type for the register-file write arbiter.
// No ports: provides DATA_WIDTH, ADDR_WIDTH, NUM_REGS and state_e.
package regfile_pkg;

  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned ADDR_WIDTH = 4;
  localparam int unsigned NUM_REGS   = 16;

  typedef enum logic [0:0] {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Requester-side bus of the write arbiter: NUM_REQ packed valid/ready lanes.
// master: requesters (drive valid/dest/data, see ready)
// slave : arbiter    (sees valid/dest/data, drives ready)
interface regfile_write_arbiter_if
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3
) ();

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_dest;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;

  modport master (
    output req_valid,
    output req_dest,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_dest,
    input  req_data,
    output req_ready
  );

endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searching from ptr+1,
// plus the pointer register that moves to the winner on advance.
// Ports: clk, rst (async active-low), req, allow (gate all grants),
//        advance (a transfer happened), grant (one-hot), grant_idx.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       allow,
  input  logic                       advance,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

  localparam int unsigned SRC_W = $clog2(NUM_REQ);

  logic [SRC_W-1:0] ptr;
  logic [SRC_W-1:0] idx;
  logic             found;

  // First requester after the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    grant     = '0;
    grant_idx = ptr;
    idx       = '0;
    found     = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = SRC_W'((32'(ptr) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        found     = 1'b1;
        grant_idx = idx;
      end
    end
    if (found && allow) begin
      grant[grant_idx] = 1'b1;
    end
  end

  // Reset value NUM_REQ-1 gives requester 0 first priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= SRC_W'(NUM_REQ - 1);
    end else if (advance) begin
      ptr <= grant_idx;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between NUM_REQ requesters (round-robin)
// and a clear sequencer that writes zero to every register, one per cycle.
// Ports: clk, rst (async active-low), bus (requester valid/ready/dest/data),
//        clear_start/clear_busy/clear_done, reg_write_en/dest/data, wr_src.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  regfile_write_arbiter_if.slave      bus,
  input  logic                        clear_start,
  output logic                        clear_busy,
  output logic                        clear_done,
  output logic                        reg_write_en,
  output logic [ADDR_WIDTH-1:0]       reg_write_dest,
  output logic [DATA_WIDTH-1:0]       reg_write_data,
  output logic [$clog2(NUM_REQ)-1:0]  wr_src
);

  localparam int unsigned SRC_W = $clog2(NUM_REQ);

  state_e                state, state_n;
  logic [ADDR_WIDTH-1:0] cnt, cnt_n;
  logic                  en_n, busy_n, done_n;
  logic [ADDR_WIDTH-1:0] dest_n;
  logic [DATA_WIDTH-1:0] data_n;
  logic [SRC_W-1:0]      src_n;

  logic                  allow;
  logic                  advance;
  logic [NUM_REQ-1:0]    grant;
  logic [SRC_W-1:0]      grant_idx;

  // Grants only in ARB, never while a clear is being started, never in reset.
  assign allow = rst && (state == ARB) && !clear_start;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (bus.req_valid),
    .allow     (allow),
    .advance   (advance),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign bus.req_ready = grant;

  // Next state and next registered outputs.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    en_n    = 1'b0;
    dest_n  = '0;
    data_n  = '0;
    src_n   = '0;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    advance = 1'b0;
    case (state)
      ARB: begin
        if (clear_start) begin
          en_n    = 1'b1;
          busy_n  = 1'b1;
          cnt_n   = ADDR_WIDTH'(1);
          state_n = CLEAR;
        end else if (|grant) begin
          advance = 1'b1;
          en_n    = 1'b1;
          dest_n  = bus.req_dest[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
          data_n  = bus.req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
          src_n   = grant_idx;
        end
      end
      CLEAR: begin
        en_n   = 1'b1;
        busy_n = 1'b1;
        dest_n = cnt;
        cnt_n  = cnt + 1'b1;
        if (cnt == ADDR_WIDTH'(NUM_REGS - 1)) begin
          done_n  = 1'b1;
          cnt_n   = '0;
          state_n = ARB;
        end
      end
      default: begin
        state_n = ARB;
        cnt_n   = '0;
      end
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ARB;
      cnt            <= '0;
      reg_write_en   <= 1'b0;
      reg_write_dest <= '0;
      reg_write_data <= '0;
      wr_src         <= '0;
      clear_busy     <= 1'b0;
      clear_done     <= 1'b0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      reg_write_en   <= en_n;
      reg_write_dest <= dest_n;
      reg_write_data <= data_n;
      wr_src         <= src_n;
      clear_busy     <= busy_n;
      clear_done     <= done_n;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: a cycle-level reference model
// pushes expected writes with their due cycle; a negedge monitor pops them.
module tb_regfile_write_arbiter;
  import regfile_pkg::*;

  localparam int unsigned NUM_REQ = 3;
  localparam int unsigned SRC_W   = $clog2(NUM_REQ);

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  clear_start = 1'b0;
  logic                  clear_busy, clear_done, reg_write_en;
  logic [ADDR_WIDTH-1:0] reg_write_dest;
  logic [DATA_WIDTH-1:0] reg_write_data;
  logic [SRC_W-1:0]      wr_src;

  regfile_write_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  regfile_write_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .clear_start    (clear_start),
    .clear_busy     (clear_busy),
    .clear_done     (clear_done),
    .reg_write_en   (reg_write_en),
    .reg_write_dest (reg_write_dest),
    .reg_write_data (reg_write_data),
    .wr_src         (wr_src)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                    cyc;
    logic [ADDR_WIDTH-1:0] dest;
    logic [DATA_WIDTH-1:0] data;
    int                    src;
    bit                    busy;
    bit                    done;
  } exp_t;

  exp_t                  q[$];
  int                    tests = 0;
  int                    fails = 0;
  int                    cyc   = 0;
  logic [DATA_WIDTH-1:0] rf      [NUM_REGS];
  logic [DATA_WIDTH-1:0] exp_mem [NUM_REGS];

  // Stand-in register file fed by the DUT write port.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reg_write_en) rf[reg_write_dest] <= reg_write_data;
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: each cycle either the head of the scoreboard is due or the port is idle.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        check("wr_en",   32'(reg_write_en),   32'd1);
        check("wr_dest", 32'(reg_write_dest), 32'(e.dest));
        check("wr_data", 32'(reg_write_data), 32'(e.data));
        check("wr_src",  32'(wr_src),         32'(e.src));
        check("busy",    32'(clear_busy),     32'(e.busy));
        check("done",    32'(clear_done),     32'(e.done));
        exp_mem[e.dest] = e.data;
      end else begin
        check("idle_en",   32'(reg_write_en), 32'd0);
        check("idle_busy", 32'(clear_busy),   32'd0);
        check("idle_done", 32'(clear_done),   32'd0);
      end
    end
  end

  // Stimulus state: pending request per requester, held until granted.
  logic [NUM_REQ-1:0]    pv;
  logic [ADDR_WIDTH-1:0] pd   [NUM_REQ];
  logic [DATA_WIDTH-1:0] pdat [NUM_REQ];
  logic                  cs;
  logic                  rst_v;
  int                    last;
  int                    clear_end;

  // Reference model for one cycle: expected ready vector and scheduled writes.
  task automatic model_eval();
    logic [NUM_REQ-1:0] exp_rdy;
    int w;
    exp_t e;
    exp_rdy = '0;
    w = -1;
    if (!rst) begin
      q.delete();
      last      = NUM_REQ - 1;
      clear_end = -1;
      check("rst_en",   32'(reg_write_en),   32'd0);
      check("rst_dest", 32'(reg_write_dest), 32'd0);
      check("rst_data", 32'(reg_write_data), 32'd0);
      check("rst_src",  32'(wr_src),         32'd0);
      check("rst_busy", 32'(clear_busy),     32'd0);
      check("rst_done", 32'(clear_done),     32'd0);
    end else if (cyc <= clear_end) begin
      // sweep in progress: no grants, clear_start ignored
    end else if (cs) begin
      for (int r = 0; r < int'(NUM_REGS); r++) begin
        e.cyc  = cyc + 1 + r;
        e.dest = ADDR_WIDTH'(r);
        e.data = '0;
        e.src  = 0;
        e.busy = 1'b1;
        e.done = (r == int'(NUM_REGS) - 1);
        q.push_back(e);
      end
      clear_end = cyc + int'(NUM_REGS) - 1;
    end else begin
      for (int k = 1; k <= int'(NUM_REQ); k++) begin
        if (w < 0 && pv[(last + k) % int'(NUM_REQ)]) w = (last + k) % int'(NUM_REQ);
      end
      if (w >= 0) begin
        exp_rdy[w] = 1'b1;
        e.cyc  = cyc + 1;
        e.dest = pd[w];
        e.data = pdat[w];
        e.src  = w;
        e.busy = 1'b0;
        e.done = 1'b0;
        q.push_back(e);
        last  = w;
        pv[w] = 1'b0;
      end
    end
    check("ready", 32'(bus.req_ready), 32'(exp_rdy));
  endtask

  // One clock: apply inputs just after the edge, then run the model.
  task automatic tick();
    @(posedge clk);
    #1;
    rst             = rst_v;
    clear_start     = cs;
    bus.req_valid   = pv;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      bus.req_dest[i*ADDR_WIDTH +: ADDR_WIDTH] = pd[i];
      bus.req_data[i*DATA_WIDTH +: DATA_WIDTH] = pdat[i];
    end
    #1;
    model_eval();
    cs = 1'b0;
  endtask

  initial begin : driver
    int n;
    n         = 0;
    pv        = '0;
    cs        = 1'b0;
    rst_v     = 1'b0;
    last      = NUM_REQ - 1;
    clear_end = -1;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      pd[i]   = '0;
      pdat[i] = '0;
    end
    for (int r = 0; r < int'(NUM_REGS); r++) begin
      rf[r]      = '0;
      exp_mem[r] = '0;
    end
    bus.req_valid = '0;
    bus.req_dest  = '0;
    bus.req_data  = '0;

    // Reset held two cycles, then a single write from requester 0.
    repeat (2) tick();
    rst_v   = 1'b1;
    pv      = 3'b001;
    pd[0]   = 4'd3;
    pdat[0] = 16'hBEEF;
    tick();
    repeat (3) tick();
    check("rf3_beef", 32'(rf[3]), 32'h0000BEEF);

    // All requesters valid continuously: back-to-back rotating grants.
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (!pv[i]) begin
          pv[i]   = 1'b1;
          pd[i]   = ADDR_WIDTH'(8 + i);
          pdat[i] = DATA_WIDTH'(32'h1000 + n);
          n++;
        end
      end
      tick();
    end
    pv = '0;
    repeat (2) tick();

    // Clear with requester 1 waiting; it is served right after the sweep.
    pv      = 3'b010;
    pd[1]   = 4'd6;
    pdat[1] = 16'h6666;
    cs      = 1'b1;
    repeat (20) tick();

    // Second clear_start pulsed mid-sweep must be ignored.
    cs = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c == 5) cs = 1'b1;
      tick();
    end

    // Reset in the middle of a sweep, then all three requesters valid.
    cs = 1'b1;
    repeat (8) tick();
    rst_v = 1'b0;
    repeat (2) tick();
    rst_v = 1'b1;
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (!pv[i]) begin
          pv[i]   = 1'b1;
          pd[i]   = ADDR_WIDTH'(12 + i);
          pdat[i] = DATA_WIDTH'(32'h3000 + c * 16 + i);
        end
      end
      tick();
    end
    pv = '0;

    // Two requesters to the same register: last granted wins.
    pv      = 3'b011;
    pd[0]   = 4'd5;
    pdat[0] = 16'h1111;
    pd[1]   = 4'd5;
    pdat[1] = 16'h2222;
    repeat (5) tick();
    check("rf5_last_wins", 32'(rf[5]), 32'h00002222);

    // Randomized traffic with occasional clears.
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (!pv[i] && $urandom_range(0, 2) == 0) begin
          pv[i]   = 1'b1;
          pd[i]   = ADDR_WIDTH'($urandom_range(0, NUM_REGS - 1));
          pdat[i] = DATA_WIDTH'($urandom);
        end
      end
      cs = ($urandom_range(0, 39) == 0);
      tick();
    end

    // Drain and compare the final register contents.
    pv = '0;
    repeat (20) tick();
    check("queue_empty", 32'(q.size()), 32'd0);
    for (int r = 0; r < int'(NUM_REGS); r++) begin
      check("rf_final", 32'(rf[r]), 32'(exp_mem[r]));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
